// File: rtl/glitch_sweep.sv
// Glitch parameter sweep sequencer: walks a delay x width grid with per-point repeats,
// firing one generator enable per selected trigger edge while the generator is idle.
module glitch_sweep #(
  parameter int DELAY_W = 16,
  parameter int WIDTH_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DELAY_W-1:0] delay_start,
  input  logic [DELAY_W-1:0] delay_stop,
  input  logic [DELAY_W-1:0] delay_step,
  input  logic [WIDTH_W-1:0] width_start,
  input  logic [WIDTH_W-1:0] width_stop,
  input  logic [WIDTH_W-1:0] width_step,
  input  logic [7:0]         repeats,
  input  logic [3:0]         mode_in,
  input  logic               trig_pol,
  input  logic               trigger,
  input  logic               glitch_ready,
  output logic               glitch_en,
  output logic [DELAY_W-1:0] glitch_delay,
  output logic [WIDTH_W-1:0] glitch_width,
  output logic [3:0]         glitch_mode,
  output logic               busy,
  output logic               done,
  output logic [15:0]        attempt_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_FIRE = 3'd2,
    S_WAIT = 3'd3,
    S_NEXT = 3'd4
  } state_t;

  state_t state_r;
  state_t state_s;

  logic [DELAY_W-1:0] delay_stop_r;
  logic [DELAY_W-1:0] delay_step_r;
  logic [WIDTH_W-1:0] width_start_r;
  logic [WIDTH_W-1:0] width_stop_r;
  logic [WIDTH_W-1:0] width_step_r;
  logic [7:0]         repeats_r;
  logic               trig_pol_r;
  logic [7:0]         rep_r;
  logic               trigger_q_r;

  logic               glitch_en_r;
  logic [DELAY_W-1:0] glitch_delay_r;
  logic [WIDTH_W-1:0] glitch_width_r;
  logic [3:0]         glitch_mode_r;
  logic               busy_r;
  logic               done_r;
  logic [15:0]        attempt_cnt_r;

  logic               edge_s;
  logic [7:0]         rep_lim_s;
  logic               rep_last_s;
  logic [WIDTH_W:0]   nw_s;
  logic [DELAY_W:0]   nd_s;
  logic               width_adv_s;
  logic               delay_adv_s;
  logic               sweep_end_s;

  // Edge selection and grid-advance arithmetic; the extra sum bit makes overflow compare above stop
  always_comb begin
    edge_s      = trig_pol_r ? (~trigger & trigger_q_r) : (trigger & ~trigger_q_r);
    rep_lim_s   = (repeats_r == 8'd0) ? 8'd0 : (repeats_r - 8'd1);
    rep_last_s  = (rep_r >= rep_lim_s);
    nw_s        = {1'b0, glitch_width_r} + {1'b0, width_step_r};
    nd_s        = {1'b0, glitch_delay_r} + {1'b0, delay_step_r};
    width_adv_s = (width_step_r != {WIDTH_W{1'b0}}) && (nw_s <= {1'b0, width_stop_r});
    delay_adv_s = (delay_step_r != {DELAY_W{1'b0}}) && (nd_s <= {1'b0, delay_stop_r});
    sweep_end_s = (state_r == S_NEXT) && !abort && rep_last_s && !width_adv_s && !delay_adv_s;
  end

  // Next-state logic; abort overrides every state
  always_comb begin
    state_s = state_r;
    if (abort) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) state_s = S_ARM;
          else       state_s = S_IDLE;
        end
        S_ARM: begin
          if (edge_s && glitch_ready) state_s = S_FIRE;
          else                        state_s = S_ARM;
        end
        S_FIRE: state_s = S_WAIT;
        S_WAIT: begin
          if (glitch_ready) state_s = S_NEXT;
          else              state_s = S_WAIT;
        end
        S_NEXT: begin
          if (sweep_end_s) state_s = S_IDLE;
          else             state_s = S_ARM;
        end
        default: state_s = S_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_s;
  end

  // Config latch, grid position, attempt counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      delay_stop_r   <= {DELAY_W{1'b0}};
      delay_step_r   <= {DELAY_W{1'b0}};
      width_start_r  <= {WIDTH_W{1'b0}};
      width_stop_r   <= {WIDTH_W{1'b0}};
      width_step_r   <= {WIDTH_W{1'b0}};
      repeats_r      <= 8'd0;
      trig_pol_r     <= 1'b0;
      rep_r          <= 8'd0;
      trigger_q_r    <= 1'b0;
      glitch_en_r    <= 1'b0;
      glitch_delay_r <= {DELAY_W{1'b0}};
      glitch_width_r <= {WIDTH_W{1'b0}};
      glitch_mode_r  <= 4'd0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      attempt_cnt_r  <= 16'd0;
    end else begin
      trigger_q_r <= trigger;
      glitch_en_r <= (state_s == S_FIRE);
      busy_r      <= (state_s != S_IDLE);
      done_r      <= sweep_end_s;
      // An enable that already went out is counted even if abort arrives alongside it
      if ((state_r == S_FIRE) && (attempt_cnt_r != 16'hFFFF)) begin
        attempt_cnt_r <= attempt_cnt_r + 16'd1;
      end
      if (!abort) begin
        case (state_r)
          S_IDLE: begin
            if (start) begin
              delay_stop_r   <= delay_stop;
              delay_step_r   <= delay_step;
              width_start_r  <= width_start;
              width_stop_r   <= width_stop;
              width_step_r   <= width_step;
              repeats_r      <= repeats;
              trig_pol_r     <= trig_pol;
              rep_r          <= 8'd0;
              glitch_delay_r <= delay_start;
              glitch_width_r <= width_start;
              glitch_mode_r  <= mode_in;
              attempt_cnt_r  <= 16'd0;
            end
          end
          S_NEXT: begin
            if (!rep_last_s) begin
              rep_r <= rep_r + 8'd1;
            end else begin
              rep_r <= 8'd0;
              if (width_adv_s) begin
                glitch_width_r <= nw_s[WIDTH_W-1:0];
              end else begin
                glitch_width_r <= width_start_r;
                if (delay_adv_s) glitch_delay_r <= nd_s[DELAY_W-1:0];
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign glitch_en    = glitch_en_r;
  assign glitch_delay = glitch_delay_r;
  assign glitch_width = glitch_width_r;
  assign glitch_mode  = glitch_mode_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign attempt_cnt  = attempt_cnt_r;

endmodule

// File: tb/tb_glitch_sweep.sv
// Scoreboard bench for glitch_sweep: stimulus pushes expected enables, a monitor pops them.
module tb_glitch_sweep;

  logic        clk = 1'b0;
  logic        rst, start, abort, trig_pol, trigger, glitch_ready;
  logic [15:0] delay_start, delay_stop, delay_step;
  logic [7:0]  width_start, width_stop, width_step, repeats;
  logic [3:0]  mode_in;
  logic        glitch_en, busy, done;
  logic [15:0] glitch_delay, attempt_cnt;
  logic [7:0]  glitch_width;
  logic [3:0]  glitch_mode;

  typedef struct {
    logic [15:0] d;
    logic [7:0]  w;
    logic [3:0]  m;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  glitch_sweep #(.DELAY_W(16), .WIDTH_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .delay_start(delay_start), .delay_stop(delay_stop), .delay_step(delay_step),
    .width_start(width_start), .width_stop(width_stop), .width_step(width_step),
    .repeats(repeats), .mode_in(mode_in), .trig_pol(trig_pol), .trigger(trigger),
    .glitch_ready(glitch_ready), .glitch_en(glitch_en), .glitch_delay(glitch_delay),
    .glitch_width(glitch_width), .glitch_mode(glitch_mode), .busy(busy), .done(done),
    .attempt_cnt(attempt_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every enable must match the oldest expected point, in the expected cycle
  always @(negedge clk) begin
    if (!rst && done) done_cnt++;
    if (!rst && glitch_en) begin
      if (sb_q.size() == 0) begin
        check("unexpected_glitch_en", 32'(glitch_delay), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("delay", 32'(glitch_delay), 32'(e.d));
        check("width", 32'(glitch_width), 32'(e.w));
        check("mode", 32'(glitch_mode), 32'(e.m));
        if (e.cyc >= 0) check("fire_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic start_sweep(input logic [15:0] ds, dp, dst, input logic [7:0] ws, wp, wst,
                             input logic [7:0] rp, input logic [3:0] md, input logic pol);
    delay_start = ds; delay_stop = dp; delay_step = dst;
    width_start = ws; width_stop = wp; width_step = wst;
    repeats = rp; mode_in = md; trig_pol = pol;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
  endtask

  // Rising trigger pulse; optionally expect an enable exactly one cycle after the edge
  task automatic rise_pulse(input bit expect_fire, input logic [15:0] d, input logic [7:0] w,
                            input logic [3:0] m);
    if (expect_fire) sb_q.push_back('{d, w, m, cyc + 1});
    trigger = 1'b1;
    tick(1);
    trigger = 1'b0;
    tick(5);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      tick(1);
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; trigger = 1'b0; glitch_ready = 1'b1;
    delay_start = 16'd0; delay_stop = 16'd0; delay_step = 16'd0;
    width_start = 8'd0; width_stop = 8'd0; width_step = 8'd0;
    repeats = 8'd0; mode_in = 4'd0; trig_pol = 1'b0;
    tick(3);
    check("rst_en", 32'(glitch_en), 32'd0);
    check("rst_delay", 32'(glitch_delay), 32'd0);
    check("rst_width", 32'(glitch_width), 32'd0);
    check("rst_mode", 32'(glitch_mode), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_attempts", 32'(attempt_cnt), 32'd0);
    rst = 1'b0;
    tick(2);

    // 1: delay axis 10,20,30; fourth edge lands after done
    start_sweep(16'd10, 16'd30, 16'd10, 8'd5, 8'd5, 8'd0, 8'd1, 4'h3, 1'b0);
    check("t1_busy", 32'(busy), 32'd1);
    rise_pulse(1'b1, 16'd10, 8'd5, 4'h3);
    rise_pulse(1'b1, 16'd20, 8'd5, 4'h3);
    rise_pulse(1'b1, 16'd30, 8'd5, 4'h3);
    rise_pulse(1'b0, 16'd0, 8'd0, 4'h0);
    wait_idle("t1_idle");
    check("t1_attempts", 32'(attempt_cnt), 32'd3);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);

    // 2: width axis with two repeats per point
    start_sweep(16'd0, 16'd0, 16'd0, 8'd2, 8'd6, 8'd2, 8'd2, 4'h5, 1'b0);
    for (int i = 0; i < 6; i++) rise_pulse(1'b1, 16'd0, 8'(2 + 2 * (i / 2)), 4'h5);
    wait_idle("t2_idle");
    check("t2_attempts", 32'(attempt_cnt), 32'd6);
    check("t2_done_cnt", 32'(done_cnt), 32'd2);

    // 3: generator busy after each enable; edges while not ready are dropped
    start_sweep(16'd100, 16'd100, 16'd0, 8'd8, 8'd8, 8'd0, 8'd3, 4'h1, 1'b0);
    sb_q.push_back('{16'd100, 8'd8, 4'h1, cyc + 1});
    trigger = 1'b1; tick(1); trigger = 1'b0; tick(1);
    glitch_ready = 1'b0; tick(20);
    trigger = 1'b1; tick(1); trigger = 1'b0; tick(87);
    glitch_ready = 1'b1; tick(4);
    sb_q.push_back('{16'd100, 8'd8, 4'h1, cyc + 1});
    trigger = 1'b1; tick(1); trigger = 1'b0; tick(2);
    glitch_ready = 1'b0; tick(3);
    trigger = 1'b1; tick(1); trigger = 1'b0; tick(3);
    glitch_ready = 1'b1; tick(2);
    rise_pulse(1'b1, 16'd100, 8'd8, 4'h1);
    wait_idle("t3_idle");
    check("t3_attempts", 32'(attempt_cnt), 32'd3);
    check("t3_done_cnt", 32'(done_cnt), 32'd3);

    // 4: width overflow past 255 ends the axis instead of wrapping to 2
    start_sweep(16'd7, 16'd7, 16'd0, 8'd250, 8'd255, 8'd4, 8'd0, 4'h2, 1'b0);
    rise_pulse(1'b1, 16'd7, 8'd250, 4'h2);
    rise_pulse(1'b1, 16'd7, 8'd254, 4'h2);
    rise_pulse(1'b0, 16'd0, 8'd0, 4'h0);
    wait_idle("t4_idle");
    check("t4_attempts", 32'(attempt_cnt), 32'd2);
    check("t4_done_cnt", 32'(done_cnt), 32'd4);

    // 5: falling-edge polarity
    start_sweep(16'd1, 16'd1, 16'd0, 8'd1, 8'd1, 8'd0, 8'd1, 4'h9, 1'b1);
    trigger = 1'b1; tick(6);
    sb_q.push_back('{16'd1, 8'd1, 4'h9, cyc + 1});
    trigger = 1'b0; tick(6);
    wait_idle("t5_idle");
    check("t5_attempts", 32'(attempt_cnt), 32'd1);
    check("t5_done_cnt", 32'(done_cnt), 32'd5);

    // 6: abort in WAIT, start with abort, start while busy, reset mid-sweep
    start_sweep(16'd10, 16'd30, 16'd10, 8'd5, 8'd5, 8'd0, 8'd1, 4'h4, 1'b0);
    rise_pulse(1'b1, 16'd10, 8'd5, 4'h4);
    sb_q.push_back('{16'd20, 8'd5, 4'h4, cyc + 1});
    trigger = 1'b1; tick(1); trigger = 1'b0;
    glitch_ready = 1'b0; tick(3);
    abort = 1'b1; tick(1); abort = 1'b0;
    check("t6_abort_busy", 32'(busy), 32'd0);
    check("t6_abort_attempts", 32'(attempt_cnt), 32'd2);
    check("t6_abort_delay", 32'(glitch_delay), 32'd20);
    check("t6_abort_width", 32'(glitch_width), 32'd5);
    tick(2);
    check("t6_abort_done_cnt", 32'(done_cnt), 32'd5);
    glitch_ready = 1'b1;
    delay_start = 16'd77; start = 1'b1; abort = 1'b1; tick(1);
    start = 1'b0; abort = 1'b0; tick(1);
    check("t6_startabort_busy", 32'(busy), 32'd0);
    check("t6_startabort_delay", 32'(glitch_delay), 32'd20);
    start_sweep(16'd10, 16'd30, 16'd10, 8'd5, 8'd5, 8'd0, 8'd1, 4'h4, 1'b0);
    delay_start = 16'd55; mode_in = 4'hE; start = 1'b1; tick(1); start = 1'b0; tick(1);
    check("t6_busy_start_delay", 32'(glitch_delay), 32'd10);
    check("t6_busy_start_mode", 32'(glitch_mode), 32'h4);
    rise_pulse(1'b1, 16'd10, 8'd5, 4'h4);
    rst = 1'b1; tick(1);
    check("t6_rst_attempts", 32'(attempt_cnt), 32'd0);
    check("t6_rst_delay", 32'(glitch_delay), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0; tick(4);
    check("t6_final_done_cnt", 32'(done_cnt), 32'd5);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
